// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button debounce front end.
`timescale 1ns/1ps
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILT,
    HELD,
    REL_FILT
  } key_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_filter.sv
// One key channel: two-flop synchroniser, debounce FSM, hold counter and event pulses.
`timescale 1ns/1ps
module key_filter
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic p_in,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = cnt_w(LONG_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  key_state_e    state_q, state_d;
  logic          s1_q, s1_d, s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_done_q, long_done_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;

  always_comb begin
    s1_d        = p_in;
    s2_d        = s1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    long_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_FILT;
          cnt_d   = '0;
        end
      end
      PRESS_FILT: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = HELD;
          press_d     = 1'b1;
          level_d     = 1'b1;
          hold_d      = '0;
          long_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = REL_FILT;
          cnt_d   = '0;
        end
      end
      REL_FILT: begin
        if (s2_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A completing release wins over a long event on the same edge.
    if ((state_q == HELD || (state_q == REL_FILT && !rel_d)) && !long_done_q) begin
      if (hold_q == HOLD_LAST) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      cnt_q       <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_scan.sv
// Debounced multi-key front end: polarity normalisation plus one key_filter per channel.
`timescale 1ns/1ps
module key_scan
  import key_pkg::*;
#(
  parameter int KEY_NUM         = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam logic [KEY_NUM-1:0] POL_MASK = (KEY_ACTIVE_LOW != 0) ? {KEY_NUM{1'b1}} : '0;

  logic [KEY_NUM-1:0] key_p;
  assign key_p = key_in ^ POL_MASK;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    key_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_filter (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .p_in     (key_p[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .long_o   (key_long[g])
    );
  end

endmodule
